// File: rtl/pulse_mixer_dac.sv
// Two-channel pulse mixer: nonlinear table mix, sampled one-pole low-pass and
// a first-order sigma-delta bitstream for an external RC reconstruction filter.
module pulse_mixer_dac #(
  parameter int SAMPLE_DIV   = 16,
  parameter int FILTER_SHIFT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] pulse1_in,
  input  logic [3:0] pulse2_in,
  input  logic       mute,
  output logic       sample_strobe,
  output logic [7:0] mix_out,
  output logic       dac_out
);

  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int AW = 8 + FILTER_SHIFT;
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          strobe;
  logic [4:0]    sum;
  logic [7:0]    mix;
  logic [7:0]    mix_rom;
  logic [AW-1:0] acc;
  logic [AW-1:0] acc_next;
  logic [7:0]    sd;
  logic [8:0]    sd_sum;

  // Strobe is registered so it reads 0 throughout reset even when SAMPLE_DIV=1.
  always_comb begin
    cnt_next = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      strobe <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      strobe <= (cnt_next == CNT_LAST);
    end
  end

  assign sample_strobe = strobe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
      mix <= '0;
    end else begin
      sum <= mute ? 5'd0 : ({1'b0, pulse1_in} + {1'b0, pulse2_in});
      mix <= mix_rom;
    end
  end

  // round(255 * T(n)/T(30)), T(n) = 95.52/(8128/n + 100)
  always_comb begin
    mix_rom = 8'd255;
    case (sum)
      5'd0:  mix_rom = 8'd0;
      5'd1:  mix_rom = 8'd11;
      5'd2:  mix_rom = 8'd23;
      5'd3:  mix_rom = 8'd34;
      5'd4:  mix_rom = 8'd44;
      5'd5:  mix_rom = 8'd55;
      5'd6:  mix_rom = 8'd65;
      5'd7:  mix_rom = 8'd75;
      5'd8:  mix_rom = 8'd85;
      5'd9:  mix_rom = 8'd94;
      5'd10: mix_rom = 8'd104;
      5'd11: mix_rom = 8'd113;
      5'd12: mix_rom = 8'd122;
      5'd13: mix_rom = 8'd130;
      5'd14: mix_rom = 8'd139;
      5'd15: mix_rom = 8'd147;
      5'd16: mix_rom = 8'd156;
      5'd17: mix_rom = 8'd164;
      5'd18: mix_rom = 8'd171;
      5'd19: mix_rom = 8'd179;
      5'd20: mix_rom = 8'd187;
      5'd21: mix_rom = 8'd194;
      5'd22: mix_rom = 8'd201;
      5'd23: mix_rom = 8'd209;
      5'd24: mix_rom = 8'd216;
      5'd25: mix_rom = 8'd222;
      5'd26: mix_rom = 8'd229;
      5'd27: mix_rom = 8'd236;
      5'd28: mix_rom = 8'd242;
      5'd29: mix_rom = 8'd249;
      5'd30: mix_rom = 8'd255;
      default: mix_rom = 8'd255;
    endcase
  end

  // Intermediate wrap is harmless: the true result never exceeds 255<<S.
  always_comb begin
    acc_next = acc + AW'(mix) - (acc >> FILTER_SHIFT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (strobe) begin
      acc <= acc_next;
    end
  end

  assign mix_out = acc[AW-1:FILTER_SHIFT];

  always_comb begin
    sd_sum = {1'b0, sd} + {1'b0, mix_out};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sd      <= '0;
      dac_out <= 1'b0;
    end else begin
      sd      <= sd_sum[7:0];
      dac_out <= sd_sum[8];
    end
  end

endmodule

// File: tb/tb_pulse_mixer_dac.sv
// Bench for pulse_mixer_dac: three instances (DIV16/S0, DIV16/S2, DIV1/S0)
// share inputs and are compared every clock against a behavioural model.
module tb_pulse_mixer_dac;

  localparam int DIV_A = 16, SH_A = 0;
  localparam int DIV_B = 16, SH_B = 2;
  localparam int DIV_C = 1,  SH_C = 0;

  logic       clk;
  logic       rst;
  logic [3:0] pulse1;
  logic [3:0] pulse2;
  logic       mute;
  logic [2:0] strobe_v;
  logic [2:0] dac_v;
  logic [7:0] mix_v [3];

  int n_cmp = 0;
  int n_err = 0;

  int div_m [3] = '{DIV_A, DIV_B, DIV_C};
  int sh_m  [3] = '{SH_A, SH_B, SH_C};
  int acc_m [3];
  int exp_strobe [3];
  int edges;
  int sum_q [$];

  pulse_mixer_dac #(.SAMPLE_DIV(DIV_A), .FILTER_SHIFT(SH_A)) u_a (
    .clk(clk), .rst(rst), .pulse1_in(pulse1), .pulse2_in(pulse2), .mute(mute),
    .sample_strobe(strobe_v[0]), .mix_out(mix_v[0]), .dac_out(dac_v[0]));
  pulse_mixer_dac #(.SAMPLE_DIV(DIV_B), .FILTER_SHIFT(SH_B)) u_b (
    .clk(clk), .rst(rst), .pulse1_in(pulse1), .pulse2_in(pulse2), .mute(mute),
    .sample_strobe(strobe_v[1]), .mix_out(mix_v[1]), .dac_out(dac_v[1]));
  pulse_mixer_dac #(.SAMPLE_DIV(DIV_C), .FILTER_SHIFT(SH_C)) u_c (
    .clk(clk), .rst(rst), .pulse1_in(pulse1), .pulse2_in(pulse2), .mute(mute),
    .sample_strobe(strobe_v[2]), .mix_out(mix_v[2]), .dac_out(dac_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 255*T(n)/T(30) simplifies to 94588*n/(8128+100*n); rounded half-up.
  function automatic int tbl(input int n);
    if (n <= 0) return 0;
    if (n >= 31) return 255;
    return (2 * 94588 * n + 8128 + 100 * n) / (2 * (8128 + 100 * n));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    edges = 0;
    sum_q.delete();
    for (int i = 0; i < 3; i++) begin
      acc_m[i] = 0;
      exp_strobe[i] = 0;
    end
  endtask

  // Filter input at edge n is the table value of the inputs sampled at edge n-2.
  task automatic model_edge();
    int mixv;
    edges++;
    mixv = (sum_q.size() >= 2) ? tbl(sum_q[sum_q.size() - 2]) : 0;
    for (int i = 0; i < 3; i++) begin
      if (edges >= 2 && (edges % div_m[i]) == 0)
        acc_m[i] = acc_m[i] + mixv - (acc_m[i] >> sh_m[i]);
      exp_strobe[i] = ((edges % div_m[i]) == div_m[i] - 1) ? 1 : 0;
    end
    sum_q.push_back(mute ? 0 : int'(pulse1) + int'(pulse2));
    if (sum_q.size() > 3) void'(sum_q.pop_front());
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("strobe_%0d", i), strobe_v[i], exp_strobe[i]);
      check($sformatf("mix_%0d", i), mix_v[i], acc_m[i] >> sh_m[i]);
      if (rst) check($sformatf("rst_dac_%0d", i), dac_v[i], 0);
    end
  endtask

  initial begin
    int first_a, val_a, b16, b32, prev_b, reach, viol, ones_a, ones_c, found;
    int pairs [4][3] = '{'{1, 0, 11}, '{8, 7, 147}, '{0, 0, 0}, '{15, 15, 255}};
    int set_hist [$];
    int s;

    rst = 1'b1; pulse1 = '0; pulse2 = '0; mute = 1'b0;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;

    // Random warm-up
    for (int k = 0; k < 50; k++) begin
      pulse1 = 4'($urandom_range(0, 15));
      pulse2 = 4'($urandom_range(0, 15));
      mute   = ($urandom_range(0, 7) == 0);
      tick();
    end

    // Asynchronous reset mid-run with 15/15 applied
    pulse1 = 4'd15; pulse2 = 4'd15; mute = 1'b0;
    repeat (20) tick();
    #2 rst = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_now_mix_%0d", i), mix_v[i], 0);
      check($sformatf("rst_now_dac_%0d", i), dac_v[i], 0);
      check($sformatf("rst_now_strobe_%0d", i), strobe_v[i], 0);
    end
    repeat (2) tick();
    rst = 1'b0;

    // First update lands on clock edge SAMPLE_DIV after release
    first_a = 0; val_a = 0; b16 = -1; b32 = -1;
    for (int k = 0; k < 32; k++) begin
      tick();
      if (first_a == 0 && mix_v[0] != 0) begin
        first_a = edges;
        val_a = mix_v[0];
      end
      if (edges == 16) b16 = mix_v[1];
      if (edges == 32) b32 = mix_v[1];
    end
    check("first_update_edge", first_a, DIV_A);
    check("s0_full_scale", val_a, 255);
    check("s2_strobe1", b16, 63);
    check("s2_strobe2", b32, 111);

    // S=2 rise: monotonic, reaches 255 within 40 strobes, holds; dac density
    prev_b = b32; reach = 0; viol = 0; ones_a = 0; ones_c = 0;
    while (edges < 45 * DIV_B) begin
      tick();
      if (mix_v[1] < prev_b) viol++;
      if (reach != 0 && mix_v[1] != 255) viol++;
      if (reach == 0 && mix_v[1] == 255) reach = edges / DIV_B;
      prev_b = mix_v[1];
      if (edges >= 100 && edges < 356) begin
        ones_a += dac_v[0];
        ones_c += dac_v[2];
      end
    end
    check("s2_monotonic_hold", viol, 0);
    check("s2_reach_within_40", (reach > 0 && reach <= 40) ? 1 : 0, 1);
    check("dac_ones_255_a", ones_a, 255);
    check("dac_ones_255_c", ones_c, 255);

    // Table anchors on S=0 instances
    for (int p = 0; p < 4; p++) begin
      pulse1 = 4'(pairs[p][0]);
      pulse2 = 4'(pairs[p][1]);
      repeat (40) tick();
      check($sformatf("anchor_a_%0d_%0d", pairs[p][0], pairs[p][1]), mix_v[0], pairs[p][2]);
      check($sformatf("anchor_c_%0d_%0d", pairs[p][0], pairs[p][1]), mix_v[2], pairs[p][2]);
    end

    // Sweep all reachable sums through the DIV=1 instance
    for (int n = 0; n <= 30; n++) begin
      pulse1 = 4'((n > 15) ? 15 : n);
      pulse2 = 4'(n - ((n > 15) ? 15 : n));
      repeat (3) tick();
      check($sformatf("sweep_%0d", n), mix_v[2], tbl(n));
    end

    // Mute from settled full scale
    pulse1 = 4'd15; pulse2 = 4'd15;
    repeat (40) tick();
    mute = 1'b1;
    found = 0;
    for (int k = 0; k < 19 && found == 0; k++) begin
      tick();
      if (mix_v[0] == 0) found = k + 1;
    end
    check("mute_within_strobe", (found > 0) ? 1 : 0, 1);
    repeat (2) tick();
    ones_a = 0; ones_c = 0;
    for (int k = 0; k < 256; k++) begin
      tick();
      ones_a += dac_v[0];
      ones_c += dac_v[2];
    end
    check("mute_dac_zero_a", ones_a, 0);
    check("mute_dac_zero_c", ones_c, 0);

    // DIV=1: toggled input tracks the table three clocks later
    mute = 1'b0; pulse2 = 4'd0;
    for (int k = 0; k < 64; k++) begin
      pulse1 = (k % 2 == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
      set_hist.push_back(int'(pulse1));
      tick();
      if (set_hist.size() >= 3) begin
        s = set_hist[set_hist.size() - 3];
        check("lat3_c", mix_v[2], tbl(s));
      end
    end

    // Random soak against the model
    for (int k = 0; k < 400; k++) begin
      pulse1 = 4'($urandom_range(0, 15));
      pulse2 = 4'($urandom_range(0, 15));
      mute   = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
